// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
// Shared types and constants for the maze game sequencer.
//   - Output field widths (level, lives, time_left, display state code).
//   - Default timing constants used as parameter defaults by maze_game_ctrl.
//   - 3-bit display codes for state_o and the internal FSM state type.
//   - state_code(): maps an internal state to its 3-bit display code.
// -----------------------------------------------------------------------------
package maze_pkg;

    localparam int LEVEL_W = 2;
    localparam int LIVES_W = 2;
    localparam int TIME_W  = 7;
    localparam int STATE_W = 3;

    localparam int DEF_NUM_LEVELS    = 4;
    localparam int DEF_LIVES         = 3;
    localparam int DEF_TIME_LIMIT    = 60;
    localparam int DEF_FPS           = 60;
    localparam int DEF_CD_SECS       = 3;
    localparam int DEF_RESULT_FRAMES = 90;
    localparam int DEF_COLL_RST_CYC  = 4;

    // Display codes presented on state_o.
    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_ARM       = 3'd1;
    localparam logic [STATE_W-1:0] ST_COUNTDOWN = 3'd2;
    localparam logic [STATE_W-1:0] ST_PLAY      = 3'd3;
    localparam logic [STATE_W-1:0] ST_WON       = 3'd4;
    localparam logic [STATE_W-1:0] ST_LOST      = 3'd5;
    localparam logic [STATE_W-1:0] ST_VICTORY   = 3'd6;
    localparam logic [STATE_W-1:0] ST_DEFEAT    = 3'd7;

    // S_PAUSED is only reachable when MAZE_PAUSE_EN is defined. The eight
    // display codes are all taken, so PAUSED is shown as PLAY (move_en=0
    // tells the two apart).
    typedef enum logic [3:0] {
        S_IDLE, S_ARM, S_COUNTDOWN, S_PLAY,
        S_WON, S_LOST, S_VICTORY, S_DEFEAT,
        S_PAUSED
    } state_e;

    function automatic logic [STATE_W-1:0] state_code(input state_e s);
        logic [STATE_W-1:0] code;
        case (s)
            S_IDLE:      code = ST_IDLE;
            S_ARM:       code = ST_ARM;
            S_COUNTDOWN: code = ST_COUNTDOWN;
            S_PLAY:      code = ST_PLAY;
            S_WON:       code = ST_WON;
            S_LOST:      code = ST_LOST;
            S_VICTORY:   code = ST_VICTORY;
            S_DEFEAT:    code = ST_DEFEAT;
            S_PAUSED:    code = ST_PLAY;
            default:     code = ST_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/maze_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// maze_game_ctrl_if
// Game-control bundle between the button/frame logic, the collision and
// player-move blocks, and the sequencer.
//   slave  (sequencer side): in  start_btn, frame_tick, win, game_over
//                            out coll_rst, move_en, level, lives, time_left,
//                                state_o, victory, defeat
//   master (environment side): the same signals with opposite directions.
// -----------------------------------------------------------------------------
interface maze_game_ctrl_if;
    import maze_pkg::*;

    logic               start_btn;
    logic               frame_tick;
    logic               win;
    logic               game_over;
    logic               coll_rst;
    logic               move_en;
    logic [LEVEL_W-1:0] level;
    logic [LIVES_W-1:0] lives;
    logic [TIME_W-1:0]  time_left;
    logic [STATE_W-1:0] state_o;
    logic               victory;
    logic               defeat;

    modport slave (
        input  start_btn, frame_tick, win, game_over,
        output coll_rst, move_en, level, lives, time_left, state_o, victory, defeat
    );

    modport master (
        output start_btn, frame_tick, win, game_over,
        input  coll_rst, move_en, level, lives, time_left, state_o, victory, defeat
    );

endinterface

// File: rtl/maze_frame_timer.sv
// -----------------------------------------------------------------------------
// maze_frame_timer
// Divides frame_tick down to one pulse per second and keeps a saturating
// frame count for result-screen timing.
//   clk, rst    : clock, asynchronous active-low reset
//   clr         : zero both counters on the next edge (state entry)
//   hold        : freeze both counters and suppress sec_p
//   frame_tick  : one-cycle pulse per video frame
//   sec_p       : high on the FPS-th tick since the last clear/wrap
//   frames_done : frame count has reached MAX_FRAMES (it stays there)
// -----------------------------------------------------------------------------
module maze_frame_timer #(
    parameter int FPS        = 60,
    parameter int MAX_FRAMES = 90
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    input  logic frame_tick,
    output logic sec_p,
    output logic frames_done
);

    localparam int SUB_W = $clog2(FPS);
    localparam int CNT_W = $clog2(MAX_FRAMES + 1);

    logic [SUB_W-1:0] sub_q, sub_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             adv;
    logic             sub_wrap;

    assign adv      = frame_tick && !hold;
    assign sub_wrap = (sub_q == SUB_W'(FPS - 1));

    // sec_p deliberately ignores clr: clr is derived from the FSM next state,
    // which itself depends on sec_p.
    assign sec_p       = adv && sub_wrap;
    assign frames_done = (cnt_q == CNT_W'(MAX_FRAMES));

    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        sub_d = sub_q;
        cnt_d = cnt_q;
        if (clr) begin
            sub_d = '0;
            cnt_d = '0;
        end else if (adv) begin
            sub_d = sub_wrap ? '0 : sub_q + SUB_W'(1);
            if (!frames_done) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: non-blocking assignments make each flop sample pre-edge values,
    // independent of statement order inside the block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub_q <= '0;
            cnt_q <= '0;
        end else begin
            sub_q <= sub_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/maze_game_ctrl.sv
// -----------------------------------------------------------------------------
// maze_game_ctrl
// Round sequencer for the maze game. Pulses the collision block's reset before
// each round, runs the pre-round countdown and the per-round time limit, gates
// player movement, and tracks level and lives from win/game_over.
//   clk   : system (pixel) clock
//   rst   : asynchronous active-low reset
//   bus   : maze_game_ctrl_if.slave
//           in  start_btn (raw, async), frame_tick, win, game_over
//           out coll_rst, move_en, level, lives, time_left, state_o,
//               victory, defeat   (all registered)
// Build option: MAZE_PAUSE_EN adds a PAUSED state toggled by start from PLAY.
// -----------------------------------------------------------------------------
module maze_game_ctrl
    import maze_pkg::*;
#(
    parameter int NUM_LEVELS    = DEF_NUM_LEVELS,
    parameter int LIVES         = DEF_LIVES,
    parameter int TIME_LIMIT    = DEF_TIME_LIMIT,
    parameter int FPS           = DEF_FPS,
    parameter int CD_SECS       = DEF_CD_SECS,
    parameter int RESULT_FRAMES = DEF_RESULT_FRAMES,
    parameter int COLL_RST_CYC  = DEF_COLL_RST_CYC
) (
    input  logic              clk,
    input  logic              rst,
    maze_game_ctrl_if.slave   bus
);

    localparam int ARM_W = $clog2(COLL_RST_CYC);

    logic [2:0]         sync_q, sync_d;
    logic               start_p;
    state_e             state_q, state_d;
    logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [TIME_W-1:0]  time_left_q, time_left_d;
    logic [STATE_W-1:0] state_o_q, state_o_d;
    logic               coll_rst_q, coll_rst_d;
    logic               move_en_q, move_en_d;
    logic               victory_q, victory_d;
    logic               defeat_q, defeat_d;
    logic               sec_p, frames_done, timeout;
    logic               tmr_clr, tmr_hold;

    // Two synchroniser flops plus one history flop; a held button gives a
    // single start_p because only the 0->1 step is seen.
    assign sync_d  = {sync_q[1:0], bus.start_btn};
    assign start_p = sync_q[1] && !sync_q[2];

    assign timeout = sec_p && (time_left_q <= TIME_W'(1));

    // Sub-counter restarts on every state change; ARM keeps it cleared so
    // frame ticks there are discarded.
`ifdef MAZE_PAUSE_EN
    logic pause_swap;
    assign pause_swap = (state_q == S_PLAY   && state_d == S_PAUSED) ||
                        (state_q == S_PAUSED && state_d == S_PLAY);
    assign tmr_hold   = (state_q == S_PAUSED);
    assign tmr_clr    = ((state_d != state_q) && !pause_swap) || (state_q == S_ARM);
`else
    assign tmr_hold   = 1'b0;
    assign tmr_clr    = (state_d != state_q) || (state_q == S_ARM);
`endif

    maze_frame_timer #(
        .FPS        (FPS),
        .MAX_FRAMES (RESULT_FRAMES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clr         (tmr_clr),
        .hold        (tmr_hold),
        .frame_tick  (bus.frame_tick),
        .sec_p       (sec_p),
        .frames_done (frames_done)
    );

    always_comb begin
        state_d     = state_q;
        arm_cnt_d   = '0;
        level_d     = level_q;
        lives_d     = lives_q;
        time_left_d = time_left_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_p) begin
                    level_d = '0;
                    lives_d = LIVES_W'(LIVES);
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (arm_cnt_q == ARM_W'(COLL_RST_CYC - 1)) begin
                    state_d = S_COUNTDOWN;
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            S_COUNTDOWN: begin
                // win/game_over are stale collision flags here and are ignored.
                if (sec_p) begin
                    if (time_left_q <= TIME_W'(1)) begin
                        time_left_d = TIME_W'(TIME_LIMIT);
                        state_d     = S_PLAY;
                    end else begin
                        time_left_d = time_left_q - TIME_W'(1);
                    end
                end
            end
            S_PLAY: begin
                if (sec_p && time_left_q != '0) begin
                    time_left_d = time_left_q - TIME_W'(1);
                end
                // A win always beats a loss or a timeout in the same cycle.
                if (bus.win) begin
                    state_d = S_WON;
                end else if (bus.game_over || timeout) begin
                    state_d = S_LOST;
                    if (lives_q != '0) begin
                        lives_d = lives_q - LIVES_W'(1);
                    end
                end
`ifdef MAZE_PAUSE_EN
                else if (start_p) begin
                    state_d = S_PAUSED;
                end
`endif
            end
            S_WON: begin
                if (frames_done) begin
                    if (level_q == LEVEL_W'(NUM_LEVELS - 1)) begin
                        state_d = S_VICTORY;
                    end else begin
                        level_d = level_q + LEVEL_W'(1);
                        state_d = S_ARM;
                    end
                end
            end
            S_LOST: begin
                if (frames_done) begin
                    state_d = (lives_q == '0) ? S_DEFEAT : S_ARM;
                end
            end
            S_VICTORY, S_DEFEAT: begin
                if (start_p) begin
                    state_d = S_IDLE;
                end
            end
`ifdef MAZE_PAUSE_EN
            S_PAUSED: begin
                if (start_p) begin
                    state_d = S_PLAY;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The countdown value is visible from the first ARM cycle.
        if (state_d == S_ARM) begin
            time_left_d = TIME_W'(CD_SECS);
        end

        // Outputs are decoded from the next state so the registered copies
        // line up with state_q.
        coll_rst_d = (state_d == S_IDLE) || (state_d == S_ARM) ||
                     (state_d == S_VICTORY) || (state_d == S_DEFEAT);
        move_en_d  = (state_d == S_PLAY);
        victory_d  = (state_d == S_VICTORY);
        defeat_d   = (state_d == S_DEFEAT);
        state_o_d  = state_code(state_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            state_q     <= S_IDLE;
            arm_cnt_q   <= '0;
            level_q     <= '0;
            lives_q     <= LIVES_W'(LIVES);
            time_left_q <= TIME_W'(TIME_LIMIT);
            state_o_q   <= ST_IDLE;
            coll_rst_q  <= 1'b1;
            move_en_q   <= 1'b0;
            victory_q   <= 1'b0;
            defeat_q    <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            arm_cnt_q   <= arm_cnt_d;
            level_q     <= level_d;
            lives_q     <= lives_d;
            time_left_q <= time_left_d;
            state_o_q   <= state_o_d;
            coll_rst_q  <= coll_rst_d;
            move_en_q   <= move_en_d;
            victory_q   <= victory_d;
            defeat_q    <= defeat_d;
        end
    end

    assign bus.coll_rst  = coll_rst_q;
    assign bus.move_en   = move_en_q;
    assign bus.level     = level_q;
    assign bus.lives     = lives_q;
    assign bus.time_left = time_left_q;
    assign bus.state_o   = state_o_q;
    assign bus.victory   = victory_q;
    assign bus.defeat    = defeat_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_maze_game_ctrl
// Self-checking bench for maze_game_ctrl with reduced timing:
// FPS=2, CD_SECS=1, RESULT_FRAMES=2, TIME_LIMIT=3, NUM_LEVELS=2, LIVES=2,
// COLL_RST_CYC=4. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_maze_game_ctrl;
    import maze_pkg::*;

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    maze_game_ctrl_if bus ();

    maze_game_ctrl #(
        .NUM_LEVELS    (2),
        .LIVES         (2),
        .TIME_LIMIT    (3),
        .FPS           (2),
        .CD_SECS       (1),
        .RESULT_FRAMES (2),
        .COLL_RST_CYC  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One step: hold inputs for cyc clocks, then compare every output.
    typedef struct {
        int st, tk, wn, go, cyc;
        int e_st, e_coll, e_mv, e_lv, e_lf, e_tl, e_vic, e_def;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int st, int tk, int wn, int go, int cyc,
                                int e_st, int e_coll, int e_mv, int e_lv,
                                int e_lf, int e_tl, int e_vic, int e_def);
        vec_t v;
        v.st = st; v.tk = tk; v.wn = wn; v.go = go; v.cyc = cyc;
        v.e_st = e_st; v.e_coll = e_coll; v.e_mv = e_mv; v.e_lv = e_lv;
        v.e_lf = e_lf; v.e_tl = e_tl; v.e_vic = e_vic; v.e_def = e_def;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input int st, input int coll,
                              input int mv, input int lv, input int lf,
                              input int tl, input int vic, input int dfe);
        check({tag, ".state"},     int'(bus.state_o),   st);
        check({tag, ".coll_rst"},  int'(bus.coll_rst),  coll);
        check({tag, ".move_en"},   int'(bus.move_en),   mv);
        check({tag, ".level"},     int'(bus.level),     lv);
        check({tag, ".lives"},     int'(bus.lives),     lf);
        check({tag, ".time_left"}, int'(bus.time_left), tl);
        check({tag, ".victory"},   int'(bus.victory),   vic);
        check({tag, ".defeat"},    int'(bus.defeat),    dfe);
    endtask

    task automatic wait_state(input int code, input int max_cyc, input string name);
        int k = 0;
        while (int'(bus.state_o) != code && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(bus.state_o), code);
    endtask

    task automatic press_start();
        bus.start_btn = 1'b1;
        @(negedge clk);
        bus.start_btn = 1'b0;
    endtask

    task automatic tick_n(input int n);
        bus.frame_tick = 1'b1;
        repeat (n) @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int arm_len;
        vec_t v;

        rst            = 1'b0;
        bus.start_btn  = 1'b0;
        bus.frame_tick = 1'b0;
        bus.win        = 1'b0;
        bus.game_over  = 1'b0;

        //                 st tk wn go cyc  state coll mv lv lf tl vic def
        vecs.push_back(mk(0, 0, 1, 1, 2,   2, 0, 0, 0, 2, 1, 0, 0)); // hits ignored in COUNTDOWN
        vecs.push_back(mk(0, 1, 0, 0, 1,   2, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1,   3, 0, 1, 0, 2, 3, 0, 0)); // 2nd tick -> PLAY
        vecs.push_back(mk(0, 1, 0, 0, 1,   3, 0, 1, 0, 2, 3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1,   4, 0, 0, 0, 2, 3, 0, 0)); // win -> WON
        vecs.push_back(mk(0, 1, 0, 0, 2,   4, 0, 0, 0, 2, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 1, 0, 1, 2, 1, 0, 0)); // next level, ARM
        vecs.push_back(mk(0, 1, 0, 0, 4,   2, 0, 0, 1, 2, 1, 0, 0)); // ticks in ARM discarded
        vecs.push_back(mk(0, 1, 0, 0, 2,   3, 0, 1, 1, 2, 3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1,   4, 0, 0, 1, 2, 3, 0, 0)); // win+game_over -> WON
        vecs.push_back(mk(0, 1, 0, 0, 2,   4, 0, 0, 1, 2, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   6, 1, 0, 1, 2, 3, 1, 0)); // VICTORY
        vecs.push_back(mk(0, 0, 0, 0, 3,   6, 1, 0, 1, 2, 3, 1, 0)); // held
        vecs.push_back(mk(1, 0, 0, 0, 6,   0, 1, 0, 1, 2, 3, 0, 0)); // held button: one start
        vecs.push_back(mk(0, 0, 0, 0, 2,   0, 1, 0, 1, 2, 3, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   0, 1, 0, 1, 2, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2,   1, 1, 0, 0, 2, 1, 0, 0)); // new game
        vecs.push_back(mk(0, 0, 0, 0, 4,   2, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2,   3, 0, 1, 0, 2, 3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2,   3, 0, 1, 0, 2, 2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2,   3, 0, 1, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2,   5, 0, 0, 0, 1, 0, 0, 0)); // timeout -> LOST
        vecs.push_back(mk(0, 1, 0, 0, 2,   5, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   1, 1, 0, 0, 1, 1, 0, 0)); // retry same level
        vecs.push_back(mk(0, 0, 0, 0, 4,   2, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2,   3, 0, 1, 0, 1, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1,   5, 0, 0, 0, 0, 3, 0, 0)); // game_over -> LOST
        vecs.push_back(mk(0, 1, 0, 0, 2,   5, 0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   7, 1, 0, 0, 0, 3, 0, 1)); // DEFEAT
        vecs.push_back(mk(1, 0, 0, 0, 1,   7, 1, 0, 0, 0, 3, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 2,   0, 1, 0, 0, 0, 3, 0, 0)); // back to IDLE

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outs("reset", 0, 1, 0, 0, 2, 3, 0, 0);

        // Start -> ARM for exactly four cycles -> COUNTDOWN.
        press_start();
        wait_state(int'(ST_ARM), 10, "start_to_arm");
        arm_len = 0;
        while (bus.state_o == ST_ARM && bus.coll_rst && arm_len < 20) begin
            arm_len++;
            @(negedge clk);
        end
        check("arm_cycles", arm_len, 4);
        check_outs("countdown_entry", 2, 0, 0, 0, 2, 1, 0, 0);

        foreach (vecs[i]) begin
            v = vecs[i];
            bus.start_btn  = (v.st != 0);
            bus.frame_tick = (v.tk != 0);
            bus.win        = (v.wn != 0);
            bus.game_over  = (v.go != 0);
            repeat (v.cyc) @(negedge clk);
            check_outs($sformatf("v%0d", i), v.e_st, v.e_coll, v.e_mv, v.e_lv,
                       v.e_lf, v.e_tl, v.e_vic, v.e_def);
        end
        bus.start_btn  = 1'b0;
        bus.frame_tick = 1'b0;
        bus.win        = 1'b0;
        bus.game_over  = 1'b0;

        // Reset in the middle of a round, button held across release.
        press_start();
        wait_state(int'(ST_ARM), 10, "s6_arm");
        wait_state(int'(ST_COUNTDOWN), 10, "s6_countdown");
        tick_n(2);
        check("s6_play", int'(bus.state_o), int'(ST_PLAY));
        tick_n(1);
        rst           = 1'b0;
        bus.start_btn = 1'b1;
        #1;
        check_outs("rst_mid_play", 0, 1, 0, 0, 2, 3, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_state(int'(ST_ARM), 10, "held_start_arm");
        check("held_start_lives", int'(bus.lives), 2);
        wait_state(int'(ST_COUNTDOWN), 10, "held_start_countdown");
        tick_n(2);
        check("held_start_play", int'(bus.state_o), int'(ST_PLAY));
        tick_n(4);
        check("pre_timeout_time", int'(bus.time_left), 1);
        tick_n(1);

        // Win arrives in the same cycle as the timeout: win takes priority.
        bus.frame_tick = 1'b1;
        bus.win        = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.win        = 1'b0;
        check("win_at_timeout.state", int'(bus.state_o), int'(ST_WON));
        check("win_at_timeout.lives", int'(bus.lives), 2);
        check("win_at_timeout.move_en", int'(bus.move_en), 0);
        tick_n(2);
        @(negedge clk);
        check("win_at_timeout.next_state", int'(bus.state_o), int'(ST_ARM));
        check("win_at_timeout.level", int'(bus.level), 1);
        bus.start_btn = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
